// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I writeback slice: data/register widths,
// load funct3 encodings and the writeback FSM state type.
package rv32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE      = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/rv32_load_align.sv
// Combinational load-data extraction: picks the byte/half/word selected by
// the address offset, sign- or zero-extends it per funct3, and flags
// misaligned accesses and unsupported load encodings.
module rv32_load_align
    import rv32_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] value,
    output logic            misaligned,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection, extension and legality checks for the load type
    always_comb begin
        byte_sel   = 8'(word >> {offset, 3'b000});
        half_sel   = offset[1] ? word[31:16] : word[15:0];
        value      = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_LB:  value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: value = {24'h000000, byte_sel};
            F3_LH: begin
                value      = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            F3_LHU: begin
                value      = {16'h0000, half_sel};
                misaligned = offset[0];
            end
            F3_LW: begin
                value      = word;
                misaligned = (offset != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32_writeback.sv
// RV32I writeback stage: sole driver of the register-file write port.
// Arbitrates ALU results against load responses (loads win), tracks a single
// outstanding load for issue-stage stalling, and registers all wb_* outputs.
// Optional feature macro: WB_MISALIGN_CHK_EN (adds ld_misalign and suppresses
// misaligned load writes).
module rv32_writeback
    import rv32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_issue_valid,
    output logic                  ld_issue_ready,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic [2:0]            ld_issue_funct3,
    input  logic [1:0]            ld_issue_offset,
    input  logic                  ld_rsp_valid,
    output logic                  ld_rsp_ready,
    input  logic [XLEN-1:0]       ld_rsp_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_we,
    output logic                  busy,
    output logic [REG_ADDR_W-1:0] busy_rd
`ifdef WB_MISALIGN_CHK_EN
    ,
    output logic                  ld_misalign
`endif
);

    wb_state_t       state;
    logic [2:0]      cap_f3;
    logic [1:0]      cap_off;

    logic            issue_xfer;
    logic            rsp_xfer;
    logic            alu_xfer;
    logic [XLEN-1:0] align_value;
    logic            align_mis;
    logic            align_illegal;
    logic            ld_write_ok;

`ifndef WB_MISALIGN_CHK_EN
    logic            align_mis_unused;
    assign align_mis_unused = align_mis;
`endif

    rv32_load_align u_align (
        .funct3     (cap_f3),
        .offset     (cap_off),
        .word       (ld_rsp_data),
        .value      (align_value),
        .misaligned (align_mis),
        .illegal    (align_illegal)
    );

    // Handshake decode, ALU stall (response priority and WAW hazard) and load write qualification
    always_comb begin
        issue_xfer = ld_issue_valid && ld_issue_ready;
        rsp_xfer   = ld_rsp_valid && ld_rsp_ready;
        alu_ready  = !((state == WB_LOAD_WAIT) && ld_rsp_valid) &&
                     !(busy && (alu_rd == busy_rd) && (alu_rd != '0));
        alu_xfer   = alu_valid && alu_ready;
`ifdef WB_MISALIGN_CHK_EN
        ld_write_ok = !align_illegal && !align_mis && (busy_rd != '0);
`else
        ld_write_ok = !align_illegal && (busy_rd != '0);
`endif
    end

    // Single-load tracking FSM with registered handshake/busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WB_IDLE;
            ld_issue_ready <= 1'b1;
            ld_rsp_ready   <= 1'b0;
            busy           <= 1'b0;
            busy_rd        <= '0;
            cap_f3         <= '0;
            cap_off        <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (issue_xfer) begin
                        state          <= WB_LOAD_WAIT;
                        ld_issue_ready <= 1'b0;
                        ld_rsp_ready   <= 1'b1;
                        busy           <= 1'b1;
                        busy_rd        <= ld_issue_rd;
                        cap_f3         <= ld_issue_funct3;
                        cap_off        <= ld_issue_offset;
                    end
                end
                WB_LOAD_WAIT: begin
                    if (rsp_xfer) begin
                        state          <= WB_IDLE;
                        ld_issue_ready <= 1'b1;
                        ld_rsp_ready   <= 1'b0;
                        busy           <= 1'b0;
                        busy_rd        <= '0;
                    end
                end
                default: begin
                    state          <= WB_IDLE;
                    ld_issue_ready <= 1'b1;
                    ld_rsp_ready   <= 1'b0;
                    busy           <= 1'b0;
                    busy_rd        <= '0;
                end
            endcase
        end
    end

    // Register-file write port: load response first, otherwise an accepted ALU result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (rsp_xfer) begin
            wb_we   <= ld_write_ok;
            wb_rd   <= busy_rd;
            wb_data <= align_value;
        end else if (alu_xfer) begin
            wb_we   <= (alu_rd != '0);
            wb_rd   <= alu_rd;
            wb_data <= alu_data;
        end else begin
            wb_we   <= 1'b0;
        end
    end

`ifdef WB_MISALIGN_CHK_EN
    // One-cycle misalignment pulse coincident with the suppressed write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_misalign <= 1'b0;
        end else begin
            ld_misalign <= rsp_xfer && align_mis;
        end
    end
`endif

endmodule

// File: tb/tb_rv32_writeback.sv
// Self-checking bench for rv32_writeback: table-driven load vectors plus
// directed ALU, hazard, arbitration and reset sequences.
module tb_rv32_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue_valid;
    logic        ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic [2:0]  ld_issue_funct3;
    logic [1:0]  ld_issue_offset;
    logic        ld_rsp_valid;
    logic        ld_rsp_ready;
    logic [31:0] ld_rsp_data;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        busy;
    logic [4:0]  busy_rd;
`ifdef WB_MISALIGN_CHK_EN
    logic        ld_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32_writeback dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .ld_issue_valid  (ld_issue_valid),
        .ld_issue_ready  (ld_issue_ready),
        .ld_issue_rd     (ld_issue_rd),
        .ld_issue_funct3 (ld_issue_funct3),
        .ld_issue_offset (ld_issue_offset),
        .ld_rsp_valid    (ld_rsp_valid),
        .ld_rsp_ready    (ld_rsp_ready),
        .ld_rsp_data     (ld_rsp_data),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .wb_we           (wb_we),
        .busy            (busy),
        .busy_rd         (busy_rd)
`ifdef WB_MISALIGN_CHK_EN
        ,
        .ld_misalign     (ld_misalign)
`endif
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic [31:0] rsp;
        logic        we;
        logic [31:0] data;
        logic        mis;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input vec_t v);
        ld_issue_valid  = 1'b1;
        ld_issue_rd     = v.rd;
        ld_issue_funct3 = v.f3;
        ld_issue_offset = v.off;
        #1;
        chk({v.name, "_issue_ready"}, 32'(ld_issue_ready), 32'd1);
        tick();
        ld_issue_valid = 1'b0;
        chk({v.name, "_busy"}, 32'(busy), 32'd1);
        chk({v.name, "_busy_rd"}, 32'(busy_rd), 32'(v.rd));
        chk({v.name, "_rsp_ready"}, 32'(ld_rsp_ready), 32'd1);
        ld_rsp_valid = 1'b1;
        ld_rsp_data  = v.rsp;
        tick();
        ld_rsp_valid = 1'b0;
        chk({v.name, "_we"}, 32'(wb_we), 32'(v.we));
        if (v.we) begin
            chk({v.name, "_rd"}, 32'(wb_rd), 32'(v.rd));
            chk({v.name, "_data"}, wb_data, v.data);
        end
        chk({v.name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({v.name, "_idle_issue_ready"}, 32'(ld_issue_ready), 32'd1);
`ifdef WB_MISALIGN_CHK_EN
        chk({v.name, "_misalign"}, 32'(ld_misalign), 32'(v.mis));
`endif
        tick();
        chk({v.name, "_we_drop"}, 32'(wb_we), 32'd0);
`ifdef WB_MISALIGN_CHK_EN
        chk({v.name, "_misalign_drop"}, 32'(ld_misalign), 32'd0);
`endif
    endtask

    initial begin
        bit chk_en;
`ifdef WB_MISALIGN_CHK_EN
        chk_en = 1'b1;
`else
        chk_en = 1'b0;
`endif
        //          name        f3      off    rd     rsp            we  data          mis
        vecs[0]  = '{"lb_off2",  3'b000, 2'd2, 5'd3,  32'h0080_0000, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{"lbu_off2", 3'b100, 2'd2, 5'd3,  32'h0080_0000, 1'b1, 32'h0000_0080, 1'b0};
        vecs[2]  = '{"lh_off2",  3'b001, 2'd2, 5'd7,  32'h8001_1234, 1'b1, 32'hFFFF_8001, 1'b0};
        vecs[3]  = '{"lhu_off2", 3'b101, 2'd2, 5'd7,  32'h8001_1234, 1'b1, 32'h0000_8001, 1'b0};
        vecs[4]  = '{"lw_off0",  3'b010, 2'd0, 5'd10, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
        vecs[5]  = '{"lb_off0",  3'b000, 2'd0, 5'd11, 32'h0000_007F, 1'b1, 32'h0000_007F, 1'b0};
        vecs[6]  = '{"lb_off3",  3'b000, 2'd3, 5'd12, 32'hAB00_0000, 1'b1, 32'hFFFF_FFAB, 1'b0};
        vecs[7]  = '{"lbu_off1", 3'b100, 2'd1, 5'd13, 32'h0000_CD00, 1'b1, 32'h0000_00CD, 1'b0};
        vecs[8]  = '{"lh_off0",  3'b001, 2'd0, 5'd14, 32'h0001_7FFF, 1'b1, 32'h0000_7FFF, 1'b0};
        vecs[9]  = '{"f3_011",   3'b011, 2'd0, 5'd15, 32'h1111_1111, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{"f3_110",   3'b110, 2'd0, 5'd15, 32'h2222_2222, 1'b0, 32'h0,         1'b0};
        vecs[11] = '{"lw_rd0",   3'b010, 2'd0, 5'd0,  32'h3333_3333, 1'b0, 32'h0,         1'b0};
        vecs[12] = '{"lh_mis",   3'b001, 2'd1, 5'd16, 32'h1234_ABCD, !chk_en, 32'hFFFF_ABCD, chk_en};
        vecs[13] = '{"lw_mis",   3'b010, 2'd1, 5'd17, 32'hCAFE_F00D, !chk_en, 32'hCAFE_F00D, chk_en};

        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue_valid = 1'b0; ld_issue_rd = '0; ld_issue_funct3 = '0; ld_issue_offset = '0;
        ld_rsp_valid = 1'b0; ld_rsp_data = '0;
        tick();
        tick();
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_busy_rd", 32'(busy_rd), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_issue_ready", 32'(ld_issue_ready), 32'd1);
        chk("rst_rsp_ready", 32'(ld_rsp_ready), 32'd0);
`ifdef WB_MISALIGN_CHK_EN
        chk("rst_misalign", 32'(ld_misalign), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // ALU write, one-cycle pulse
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1 chk("alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("alu_we", 32'(wb_we), 32'd1);
        chk("alu_rd", 32'(wb_rd), 32'd5);
        chk("alu_data", wb_data, 32'hDEAD_BEEF);
        tick();
        chk("alu_we_drop", 32'(wb_we), 32'd0);

        // ALU to x0: accepted, no write
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
        #1 chk("alu_x0_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("alu_x0_we", 32'(wb_we), 32'd0);
        tick();

        foreach (vecs[i]) do_load(vecs[i]);

        // WAW hazard: ALU to the pending load's rd stalls until the response
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9; ld_issue_funct3 = 3'b010; ld_issue_offset = 2'd0;
        tick();
        ld_issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA1A1_A1A1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("waw_stall", 32'(alu_ready), 32'd0);
            tick();
            chk("waw_no_we", 32'(wb_we), 32'd0);
        end
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0909_0909;
        #1 chk("waw_rsp_prio", 32'(alu_ready), 32'd0);
        tick();
        ld_rsp_valid = 1'b0;
        chk("waw_ld_we", 32'(wb_we), 32'd1);
        chk("waw_ld_data", wb_data, 32'h0909_0909);
        chk("waw_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("waw_alu_we", 32'(wb_we), 32'd1);
        chk("waw_alu_rd", 32'(wb_rd), 32'd9);
        chk("waw_alu_data", wb_data, 32'hA1A1_A1A1);
        tick();

        // Simultaneous response and unrelated ALU result: load first
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd20; ld_issue_funct3 = 3'b010; ld_issue_offset = 2'd0;
        tick();
        ld_issue_valid = 1'b0;
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h5555_AAAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_0044;
        #1 chk("sim_alu_held", 32'(alu_ready), 32'd0);
        tick();
        ld_rsp_valid = 1'b0;
        chk("sim_ld_we", 32'(wb_we), 32'd1);
        chk("sim_ld_rd", 32'(wb_rd), 32'd20);
        chk("sim_ld_data", wb_data, 32'h5555_AAAA);
        tick();
        alu_valid = 1'b0;
        chk("sim_alu_we", 32'(wb_we), 32'd1);
        chk("sim_alu_rd", 32'(wb_rd), 32'd4);
        chk("sim_alu_data", wb_data, 32'h0000_0044);
        tick();
        chk("sim_we_drop", 32'(wb_we), 32'd0);

        // Asynchronous reset while a load is outstanding
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd21; ld_issue_funct3 = 3'b010; ld_issue_offset = 2'd0;
        tick();
        ld_issue_valid = 1'b0;
        chk("ar_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_busy_rd", 32'(busy_rd), 32'd0);
        chk("ar_rsp_ready", 32'(ld_rsp_ready), 32'd0);
        rst_n = 1'b1;
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h7777_7777;
        tick();
        chk("ar_late_rsp_we", 32'(wb_we), 32'd0);
        chk("ar_late_rsp_ready", 32'(ld_rsp_ready), 32'd0);
        chk("ar_idle_issue_ready", 32'(ld_issue_ready), 32'd1);
        tick();
        chk("ar_late_rsp_we2", 32'(wb_we), 32'd0);
        ld_rsp_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
